// File: rtl/instruction_fetcher.sv
// rtl/instruction_fetcher.sv - instruction fetch unit with one-entry last-fetch buffer
module instruction_fetcher (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetcher_reset,
  input  logic [31:0] pc,
  output logic        fetcher_completed,
  output logic [31:0] instruction,
  input  logic        invalidate,
  output logic        mem_req,
  output logic [29:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  logic [1:0]  state;
  logic [29:0] buf_tag;
  logic        buf_valid;
  logic        buf_hit;

  // The buffered word is always the one on instruction, so a hit only needs the tag.
  assign buf_hit = buf_valid && (buf_tag == pc[31:2]) && !invalidate;

  // Fetch FSM, memory port and last-fetch buffer; a started request is never cancelled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= ST_IDLE;
      fetcher_completed <= 1'b0;
      instruction       <= 32'd0;
      mem_req           <= 1'b0;
      mem_addr          <= 30'd0;
      buf_tag           <= 30'd0;
      buf_valid         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fetcher_reset) begin
            mem_addr <= pc[31:2];
            if (buf_hit) begin
              fetcher_completed <= 1'b1;
              state             <= ST_DONE;
            end else begin
              mem_req <= 1'b1;
              state   <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          // An ack wins over a simultaneous abort: the word is delivered normally.
          if (mem_ack) begin
            instruction       <= mem_rdata;
            fetcher_completed <= 1'b1;
            mem_req           <= 1'b0;
            buf_tag           <= mem_addr;
            buf_valid         <= 1'b1;
            state             <= ST_DONE;
          end else if (fetcher_reset) begin
            state <= ST_DRAIN;
          end
        end
        ST_DONE: begin
          if (fetcher_reset) begin
            fetcher_completed <= 1'b0;
            state             <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          // Aborted request: wait out the ack and drop the data.
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: begin
          mem_req           <= 1'b0;
          fetcher_completed <= 1'b0;
          state             <= ST_IDLE;
        end
      endcase
      // Placed last so it overrides a same-cycle refill.
      if (invalidate) buf_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instruction_fetcher.sv
// tb/tb_instruction_fetcher.sv - scoreboard bench for instruction_fetcher
module tb_instruction_fetcher;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetcher_reset;
  logic [31:0] pc;
  logic        fetcher_completed;
  logic [31:0] instruction;
  logic        invalidate;
  logic        mem_req;
  logic [29:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  instruction_fetcher dut (
    .clk               (clk),
    .reset             (reset),
    .fetcher_reset     (fetcher_reset),
    .pc                (pc),
    .fetcher_completed (fetcher_completed),
    .instruction       (instruction),
    .invalidate        (invalidate),
    .mem_req           (mem_req),
    .mem_addr          (mem_addr),
    .mem_ack           (mem_ack),
    .mem_rdata         (mem_rdata)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  int cyc = 0;
  // edge counter; during the period after edge k, cyc == k
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] instr;
    int          cyc;
  } sb_t;
  sb_t sb_q[$];

  logic [29:0] exp_addr = 30'd0;
  int          ack_delay = 1;
  logic [31:0] mem_word = 32'd0;
  int          req_cnt = 0;
  int          req_starts = 0;
  int          last_req_len = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // memory model: acks the ack_delay-th request cycle, checks address on every request cycle
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(posedge clk or posedge reset);
      #1;
      if (reset) begin
        req_cnt = 0;
        mem_ack = 1'b0;
      end else if (mem_req) begin
        req_cnt++;
        if (req_cnt == 1) req_starts++;
        chk("mem_addr", {2'b00, mem_addr}, {2'b00, exp_addr});
        mem_ack   = (req_cnt == ack_delay);
        mem_rdata = mem_ack ? mem_word : 32'hBAD0_BAD0;
        if (mem_ack) last_req_len = req_cnt;
      end else begin
        req_cnt = 0;
        mem_ack = 1'b0;
      end
    end
  end

  // monitor: pops the scoreboard on each completion and watches the held word
  logic        fc_prev = 1'b0;
  logic [31:0] held = 32'd0;
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      if (fetcher_completed && !fc_prev) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_completion: got instruction %h with none expected (cycle %0d)", instruction, cyc);
        end else begin
          e = sb_q.pop_front();
          chk("completion_word", instruction, e.instr);
          chk("completion_cycle", cyc, e.cyc);
        end
        held = instruction;
      end else if (fetcher_completed && fc_prev) begin
        chk("instruction_held", instruction, held);
      end
      if (fetcher_completed) chk("no_req_in_done", {31'd0, mem_req}, 32'd0);
      fc_prev = fetcher_completed;
    end
  end

  // one fetch; delay 0 means a buffer hit, otherwise ack comes in request cycle 'delay'
  task automatic do_fetch(input logic [31:0] pcv, input logic [31:0] word, input int delay,
                          input bit scribble, input bit inv_ack, input bit rel_at_ack);
    int s;
    int r0;
    @(posedge clk); #1;
    pc            = pcv;
    fetcher_reset = 1'b0;
    exp_addr      = pcv[31:2];
    ack_delay     = delay;
    mem_word      = word;
    s             = cyc + 1;
    r0            = req_starts;
    sb_q.push_back('{word, s + delay});
    for (int j = 0; j < delay; j++) begin
      @(posedge clk); #1;
      if (scribble && j == 0) pc = 32'hFFFF_FFFC;
      invalidate = inv_ack && (j + 1 == delay);
      if (rel_at_ack && (j + 1 == delay)) fetcher_reset = 1'b1;
    end
    @(posedge clk); #1;
    invalidate = 1'b0;
    chk("completed_on_time", {31'd0, fetcher_completed}, 32'd1);
    if (!rel_at_ack) begin
      repeat (2) @(posedge clk);
      #1 fetcher_reset = 1'b1;
    end
    @(posedge clk); #1;
    chk("release_drop", {31'd0, fetcher_completed}, 32'd0);
    chk("release_instr", instruction, word);
    chk("req_count", req_starts - r0, (delay > 0) ? 1 : 0);
    if (delay > 0) chk("req_len", last_req_len, delay);
  endtask

  initial begin
    int s;
    int r0;
    reset         = 1'b1;
    fetcher_reset = 1'b1;
    pc            = 32'd0;
    invalidate    = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_completed", {31'd0, fetcher_completed}, 32'd0);
    chk("rst_instruction", instruction, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", {2'b00, mem_addr}, 32'd0);

    do_fetch(32'h100, 32'hDEAD_BEEF, 1, 0, 0, 0);
    do_fetch(32'h100, 32'hDEAD_BEEF, 0, 0, 0, 0);
    do_fetch(32'h103, 32'hDEAD_BEEF, 0, 0, 0, 0);
    @(posedge clk); #1 invalidate = 1'b1;
    @(posedge clk); #1 invalidate = 1'b0;
    do_fetch(32'h100, 32'hDEAD_BEEF, 2, 0, 0, 0);
    do_fetch(32'h200, 32'h1234_5678, 5, 1, 0, 0);
    do_fetch(32'h200, 32'h1234_5678, 0, 0, 0, 0);

    // abort in request cycle 2, ack in cycle 4, new (hit) fetch requested during drain
    @(posedge clk); #1;
    pc            = 32'h300;
    fetcher_reset = 1'b0;
    exp_addr      = 30'h0C0;
    ack_delay     = 4;
    mem_word      = 32'hAAAA_AAAA;
    s             = cyc + 1;
    r0            = req_starts;
    sb_q.push_back('{32'h1234_5678, s + 5});
    @(posedge clk); #1;
    @(posedge clk); #1 fetcher_reset = 1'b1;
    @(posedge clk); #1;
    fetcher_reset = 1'b0;
    pc            = 32'h200;
    chk("drain_req3", {31'd0, mem_req}, 32'd1);
    @(posedge clk); #1;
    chk("drain_req4", {31'd0, mem_req}, 32'd1);
    @(posedge clk); #1;
    chk("drain_idle_req", {31'd0, mem_req}, 32'd0);
    chk("drain_no_complete", {31'd0, fetcher_completed}, 32'd0);
    chk("drain_instr", instruction, 32'h1234_5678);
    @(posedge clk); #1;
    chk("after_drain_hit", {31'd0, fetcher_completed}, 32'd1);
    chk("drain_req_count", req_starts - r0, 1);
    chk("drain_req_len", last_req_len, 4);
    @(posedge clk); #1 fetcher_reset = 1'b1;
    @(posedge clk); #1;
    chk("drain_release", {31'd0, fetcher_completed}, 32'd0);

    do_fetch(32'h300, 32'h0BAD_F00D, 1, 0, 0, 0);
    do_fetch(32'h400, 32'h55AA_55AA, 3, 0, 0, 1);
    do_fetch(32'h400, 32'h55AA_55AA, 0, 0, 0, 0);
    do_fetch(32'h500, 32'h0F0F_0F0F, 2, 0, 1, 0);
    do_fetch(32'h500, 32'h0F0F_0F0F, 1, 0, 0, 0);

    // async reset between edges during a long request
    @(posedge clk); #1;
    pc            = 32'h600;
    fetcher_reset = 1'b0;
    exp_addr      = 30'h180;
    ack_delay     = 10;
    mem_word      = 32'h7777_7777;
    repeat (3) @(posedge clk);
    #3;
    chk("pre_reset_req", {31'd0, mem_req}, 32'd1);
    reset = 1'b1;
    #1;
    chk("async_mem_req", {31'd0, mem_req}, 32'd0);
    chk("async_completed", {31'd0, fetcher_completed}, 32'd0);
    chk("async_instruction", instruction, 32'd0);
    fetcher_reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b0;
    do_fetch(32'h500, 32'h0F0F_0F0F, 1, 0, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish within 200000 ns");
    $fatal(1);
  end

endmodule
